// File: rtl/meta_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : meta_write_sched
// Description : Arbitrates up to four L1 meta-array write requesters onto the
//               single write port. Fixed priority (in0 highest) with
//               per-requester starvation promotion; the winner is captured
//               in a one-entry output register that retimes the array port.
// Revision    : 1.0 - initial release
// ============================================================================
module meta_write_sched #(
  parameter int IDX_W        = 6,
  parameter int WAY_W        = 8,
  parameter int TAG_W        = 20,
  parameter int STARVE_LIMIT = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_0_valid,
  output logic             io_in_0_ready,
  input  logic [IDX_W-1:0] io_in_0_bits_idx,
  input  logic [WAY_W-1:0] io_in_0_bits_way_en,
  input  logic [TAG_W-1:0] io_in_0_bits_tag,
  input  logic             io_in_1_valid,
  output logic             io_in_1_ready,
  input  logic [IDX_W-1:0] io_in_1_bits_idx,
  input  logic [WAY_W-1:0] io_in_1_bits_way_en,
  input  logic [TAG_W-1:0] io_in_1_bits_tag,
  input  logic             io_in_2_valid,
  output logic             io_in_2_ready,
  input  logic [IDX_W-1:0] io_in_2_bits_idx,
  input  logic [WAY_W-1:0] io_in_2_bits_way_en,
  input  logic [TAG_W-1:0] io_in_2_bits_tag,
  input  logic             io_in_3_valid,
  output logic             io_in_3_ready,
  input  logic [IDX_W-1:0] io_in_3_bits_idx,
  input  logic [WAY_W-1:0] io_in_3_bits_way_en,
  input  logic [TAG_W-1:0] io_in_3_bits_tag,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [IDX_W-1:0] io_out_bits_idx,
  output logic [WAY_W-1:0] io_out_bits_way_en,
  output logic [TAG_W-1:0] io_out_bits_tag,
  output logic [1:0]       io_out_bits_src
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  // Requester fields gathered into arrays so the arbiter can index them.
  logic [3:0]       w_valid;
  logic [IDX_W-1:0] w_idx [4];
  logic [WAY_W-1:0] w_way [4];
  logic [TAG_W-1:0] w_tag [4];

  assign w_valid = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
  assign w_idx[0] = io_in_0_bits_idx;
  assign w_idx[1] = io_in_1_bits_idx;
  assign w_idx[2] = io_in_2_bits_idx;
  assign w_idx[3] = io_in_3_bits_idx;
  assign w_way[0] = io_in_0_bits_way_en;
  assign w_way[1] = io_in_1_bits_way_en;
  assign w_way[2] = io_in_2_bits_way_en;
  assign w_way[3] = io_in_3_bits_way_en;
  assign w_tag[0] = io_in_0_bits_tag;
  assign w_tag[1] = io_in_1_bits_tag;
  assign w_tag[2] = io_in_2_bits_tag;
  assign w_tag[3] = io_in_3_bits_tag;

  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_idx;
  logic [WAY_W-1:0] r_out_way;
  logic [TAG_W-1:0] r_out_tag;
  logic [1:0]       r_out_src;
  logic [CNT_W-1:0] r_starve_cnt [4];

  logic       w_load;
  logic [3:0] w_starved;
  logic [3:0] w_grant;
  logic [3:0] w_fire;
  logic       w_found;
  logic [1:0] w_src;

  // The output slot is free when empty or draining; reset blocks all fires.
  assign w_load = ~reset & (~r_out_valid | io_out_ready);

  // Grant: lowest-index starved requester first, else lowest-index valid.
  always_comb begin
    w_found = 1'b0;
    w_src   = 2'd0;
    for (int n = 0; n < 4; n++) begin
      w_starved[n] = w_valid[n] & (r_starve_cnt[n] == C_LIMIT);
    end
    for (int n = 0; n < 4; n++) begin
      if (!w_found && w_starved[n]) begin
        w_found = 1'b1;
        w_src   = 2'(n);
      end
    end
    for (int n = 0; n < 4; n++) begin
      if (!w_found && w_valid[n]) begin
        w_found = 1'b1;
        w_src   = 2'(n);
      end
    end
    w_grant = w_found ? (4'b0001 << w_src) : 4'b0000;
  end

  // Grant only ever names a valid requester, so ready doubles as fire.
  assign w_fire = {4{w_load}} & w_grant;

  assign io_in_0_ready = w_fire[0];
  assign io_in_1_ready = w_fire[1];
  assign io_in_2_ready = w_fire[2];
  assign io_in_3_ready = w_fire[3];

  // One-entry output register: loads the winner or drains, otherwise holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_way   <= '0;
      r_out_tag   <= '0;
      r_out_src   <= '0;
    end else if (w_load) begin
      r_out_valid <= w_found;
      if (w_found) begin
        r_out_idx <= w_idx[w_src];
        r_out_way <= w_way[w_src];
        r_out_tag <= w_tag[w_src];
        r_out_src <= w_src;
      end
    end
  end

  // Starvation counters: count arbitrations lost to another requester,
  // saturating at the limit; backpressured cycles are not losses.
  generate
    for (genvar g = 0; g < 4; g++) begin : g_starve
      always_ff @(posedge clock) begin
        if (reset || !w_valid[g] || w_fire[g]) begin
          r_starve_cnt[g] <= '0;
        end else if (w_load && (|w_fire) && (r_starve_cnt[g] < C_LIMIT)) begin
          r_starve_cnt[g] <= r_starve_cnt[g] + 1'b1;
        end
      end
    end
  endgenerate

  assign io_out_valid       = r_out_valid;
  assign io_out_bits_idx    = r_out_idx;
  assign io_out_bits_way_en = r_out_way;
  assign io_out_bits_tag    = r_out_tag;
  assign io_out_bits_src    = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_meta_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_meta_write_sched
// Description : Self-checking bench for meta_write_sched. A reference
//               arbiter predicts readies each cycle and pushes the expected
//               output entry into a scoreboard queue on every fire; entries
//               are compared while presented and popped on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_meta_write_sched;

  localparam int C_LIMIT = 7;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] in_valid;
  logic [5:0] in_idx [4];
  logic [7:0] in_way [4];
  logic [19:0] in_tag [4];
  logic       out_ready;

  logic       rdy0, rdy1, rdy2, rdy3;
  logic       out_valid;
  logic [5:0] out_idx;
  logic [7:0] out_way;
  logic [19:0] out_tag;
  logic [1:0] out_src;
  logic [3:0] in_ready;

  assign in_ready = {rdy3, rdy2, rdy1, rdy0};

  always #5 clock = ~clock;

  meta_write_sched #(.IDX_W(6), .WAY_W(8), .TAG_W(20), .STARVE_LIMIT(C_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .io_in_0_valid(in_valid[0]), .io_in_0_ready(rdy0), .io_in_0_bits_idx(in_idx[0]),
    .io_in_0_bits_way_en(in_way[0]), .io_in_0_bits_tag(in_tag[0]),
    .io_in_1_valid(in_valid[1]), .io_in_1_ready(rdy1), .io_in_1_bits_idx(in_idx[1]),
    .io_in_1_bits_way_en(in_way[1]), .io_in_1_bits_tag(in_tag[1]),
    .io_in_2_valid(in_valid[2]), .io_in_2_ready(rdy2), .io_in_2_bits_idx(in_idx[2]),
    .io_in_2_bits_way_en(in_way[2]), .io_in_2_bits_tag(in_tag[2]),
    .io_in_3_valid(in_valid[3]), .io_in_3_ready(rdy3), .io_in_3_bits_idx(in_idx[3]),
    .io_in_3_bits_way_en(in_way[3]), .io_in_3_bits_tag(in_tag[3]),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_bits_idx(out_idx), .io_out_bits_way_en(out_way),
    .io_out_bits_tag(out_tag), .io_out_bits_src(out_src)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: output-slot occupancy, starvation counts, scoreboard.
  logic         m_ov = 1'b0;
  int           m_cnt [4] = '{0, 0, 0, 0};
  logic [35:0]  exp_q [$];
  logic [3:0]   last_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_data();
    for (int n = 0; n < 4; n++) begin
      in_idx[n] = 6'($urandom);
      in_way[n] = 8'(1 << $urandom_range(0, 7));
      in_tag[n] = 20'($urandom);
    end
  endtask

  // One clock: predict and check at the falling edge, update the model,
  // then return just after the rising edge for the caller to drive inputs.
  task automatic cycle();
    logic       ld;
    logic [3:0] g;
    int         w;
    @(negedge clock);
    ld = !reset && (!m_ov || out_ready);
    w  = -1;
    for (int n = 0; n < 4; n++) if (w < 0 && in_valid[n] && m_cnt[n] == C_LIMIT) w = n;
    for (int n = 0; n < 4; n++) if (w < 0 && in_valid[n]) w = n;
    g = 4'b0000;
    if (ld && w >= 0) g[w] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(g));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov && exp_q.size() > 0) begin
      check("out_bits", 64'({out_idx, out_way, out_tag, out_src}), 64'(exp_q[0]));
      if (out_ready) void'(exp_q.pop_front());
    end
    last_ready = in_ready;
    if (reset) begin
      m_ov = 1'b0;
      for (int n = 0; n < 4; n++) m_cnt[n] = 0;
      exp_q.delete();
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (!in_valid[n] || g[n]) m_cnt[n] = 0;
        else if (ld && g != 4'b0000 && m_cnt[n] < C_LIMIT) m_cnt[n]++;
      end
      if (ld) begin
        if (g != 4'b0000) begin
          exp_q.push_back({in_idx[w], in_way[w], in_tag[w], 2'(w)});
          m_ov = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int wins0;
    int run;
    logic seen3;
    reset     = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    rand_data();

    // Reset held two cycles with every requester valid.
    repeat (2) cycle();

    // Priority and 1-cycle latency: in0 beats in2.
    reset     = 1'b0;
    in_valid  = 4'b0101;
    in_idx[0] = 6'h05;
    in_tag[0] = 20'hABCDE;
    in_way[0] = 8'h10;
    cycle();
    check("prio_in2_wait", 64'(last_ready[2]), 64'd0);
    check("prio_out_idx", 64'(out_idx), 64'h05);
    check("prio_out_src", 64'(out_src), 64'd0);
    check("prio_out_tag", 64'(out_tag), 64'hABCDE);
    in_valid = 4'b0100;
    cycle();

    // Backpressure: slot full, array not ready, for five cycles.
    in_valid  = 4'b0110;
    out_ready = 1'b0;
    repeat (5) begin
      rand_data();
      cycle();
    end
    // Release: in1 should win seven times before in2 is promoted.
    out_ready = 1'b1;
    repeat (10) begin
      rand_data();
      cycle();
    end
    in_valid = 4'b0000;
    repeat (2) cycle();

    // Starvation of in3 against continuously-valid in0.
    in_valid = 4'b1001;
    wins0    = 0;
    seen3    = 1'b0;
    for (int i = 0; i < 20 && !seen3; i++) begin
      rand_data();
      cycle();
      if (last_ready[3]) seen3 = 1'b1;
      else if (last_ready[0]) wins0++;
    end
    check("starve_in3_won", 64'(seen3), 64'd1);
    check("starve_in0_wins", 64'(wins0), 64'd7);
    // in3's counter restarted: in0 gets another run of seven.
    repeat (9) begin
      rand_data();
      cycle();
    end
    in_valid = 4'b0000;
    repeat (2) cycle();

    // Back-to-back: four requests on in1, no bubbles.
    in_valid = 4'b0010;
    run = 0;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      cycle();
      if (out_valid) run++;
    end
    check("b2b_run", 64'(run), 64'd4);
    in_valid = 4'b0000;
    cycle();
    check("b2b_drain", 64'(out_valid), 64'd0);

    // Random traffic with random backpressure.
    repeat (200) begin
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
    end

    // Mid-operation reset with a stalled pending write.
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    rand_data();
    cycle();
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    cycle();
    check("midrst_pending", 64'(out_valid), 64'd1);
    reset    = 1'b1;
    in_valid = 4'hF;
    cycle();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_no_ready", 64'(last_ready), 64'd0);
    reset     = 1'b0;
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    rand_data();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
